// File: rtl/prm_chk_pkg.sv
// Shared widths, timer width and FSM state encoding for the parameter sweep controller.
package prm_chk_pkg;
  localparam int IDX_W     = 14;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 128;
  localparam int BANK_W    = 3;
  localparam int WSEL_W    = 4;
  localparam int WCNT_W    = BANK_W + WSEL_W;
  localparam int TMR_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CLEAR,
    ST_SAMPLE,
    ST_READ,
    ST_EMIT,
    ST_NEXT
  } state_e;
endpackage

// File: rtl/prm_sweep_ctrl_if.sv
// Result stream carrying one accumulator word per beat, with its index and end-of-index flag.
interface prm_sweep_ctrl_if;
  import prm_chk_pkg::*;

  logic [WORD_W-1:0] m_data;
  logic [IDX_W-1:0]  m_idx;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_idx, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_idx, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/prm_cycle_timer.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module prm_cycle_timer
  import prm_chk_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);
  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/prm_sweep_ctrl.sv
// Sweeps an index range: settle, clear and sample the sticky accumulator, then stream out its 128 words.
//   state  | meaning
//   IDLE   | waiting for start
//   SETTLE | idx_out held while the datapath settles
//   CLEAR  | one-cycle accumulator clear
//   SAMPLE | accumulator OR-enable window
//   READ   | word select applied, readout captured
//   EMIT   | beat offered until accepted
//   NEXT   | last-index compare, then advance or finish
module prm_sweep_ctrl
  import prm_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 256
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  idx_first,
  input  logic [IDX_W-1:0]  idx_last,
  output logic [IDX_W-1:0]  idx_out,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [BANK_W-1:0] sel1,
  output logic [WSEL_W-1:0] sel2,
  input  logic [WORD_W-1:0] rd_data,
  prm_sweep_ctrl_if.master  m_if,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SAMPLE_LD = TMR_W'(SAMPLE_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WORD_MAX  = WCNT_W'(NUM_WORDS - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q, last_q, m_idx_q;
  logic [WCNT_W-1:0]   word_q;
  logic [WORD_W-1:0]   m_data_q;
  logic                m_last_q, m_valid_q, acc_clr_q, acc_en_q, busy_q, done_q, err_q;
  logic                tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]    tmr_val;

  // Timer is reloaded in every state that precedes a timed window.
  assign tmr_load = (state_q == ST_IDLE) || (state_q == ST_NEXT) || (state_q == ST_CLEAR);
  assign tmr_val  = (state_q == ST_CLEAR) ? SAMPLE_LD : SETTLE_LD;
  assign tmr_en   = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

  prm_cycle_timer u_timer (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      word_q    <= '0;
      m_data_q  <= '0;
      m_idx_q   <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (abort) begin
      state_q   <= ST_IDLE;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (idx_first <= idx_last) begin
              idx_q   <= idx_first;
              last_q  <= idx_last;
              word_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_SETTLE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_expired) begin
            acc_clr_q <= 1'b1;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          acc_en_q <= 1'b1;
          state_q  <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (tmr_expired) begin
            acc_en_q <= 1'b0;
            state_q  <= ST_READ;
          end
        end
        ST_READ: begin
          m_data_q  <= rd_data;
          m_idx_q   <= idx_q;
          m_last_q  <= (word_q == WORD_MAX);
          m_valid_q <= 1'b1;
          state_q   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (m_if.m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (word_q == WORD_MAX) begin
              state_q <= ST_NEXT;
            end else begin
              word_q  <= word_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_NEXT: begin
          // Compare before incrementing so a sweep ending at the top index never wraps.
          if (idx_q == last_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            word_q  <= '0;
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idx_out     = idx_q;
  assign sel1        = word_q[WCNT_W-1:WSEL_W];
  assign sel2        = word_q[WSEL_W-1:0];
  assign acc_clr     = acc_clr_q;
  assign acc_en      = acc_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_if.m_data  = m_data_q;
  assign m_if.m_idx   = m_idx_q;
  assign m_if.m_last  = m_last_q;
  assign m_if.m_valid = m_valid_q;
endmodule

// File: tb/tb_prm_sweep_ctrl.sv
// Randomized bench for prm_sweep_ctrl: sticky accumulator environment plus beat/timing reference checks.
module tb_prm_sweep_ctrl;
  import prm_chk_pkg::*;

  localparam int SETTLE = 2;
  localparam int SAMPLE = 4;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [IDX_W-1:0]  idx_first = '0;
  logic [IDX_W-1:0]  idx_last = '0;
  logic [IDX_W-1:0]  idx_out;
  logic              acc_clr, acc_en, busy, done, err;
  logic [BANK_W-1:0] sel1;
  logic [WSEL_W-1:0] sel2;
  logic [WORD_W-1:0] rd_data;

  prm_sweep_ctrl_if m_if();

  prm_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .start     (start),
    .abort     (abort),
    .idx_first (idx_first),
    .idx_last  (idx_last),
    .idx_out   (idx_out),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .sel1      (sel1),
    .sel2      (sel2),
    .rd_data   (rd_data),
    .m_if      (m_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sticky accumulator: cleared on acc_clr, ORs sparse random hits while acc_en is high.
  bit [WORD_W-1:0] acc [NUM_WORDS];
  always @(posedge CLK) begin
    if (acc_clr) begin
      for (int w = 0; w < NUM_WORDS; w++) acc[w] <= '0;
    end else if (acc_en) begin
      for (int w = 0; w < NUM_WORDS; w++) acc[w] <= acc[w] | ($urandom & $urandom);
    end
  end
  assign rd_data = acc[{sel1, sel2}];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int rdy_mode = 0;
  int t0 = 0, beats = 0, clr_cnt = 0, en_cnt = 0, en_runs = 0;
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, valid_cnt = 0;
  int first_clr_rel = -1, first_en_rel = -1, err_rel = -1;
  logic [IDX_W-1:0]  cur_first = '0;
  bit                wrapped = 1'b0;
  logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_skip = 1'b1, prev_en = 1'b0;
  logic [WORD_W-1:0] prev_data = '0;
  logic [IDX_W-1:0]  prev_idx = '0;
  logic              prev_last = 1'b0;

  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       m_if.m_ready = 1'b1;
      1:       m_if.m_ready = (cyc % 3 == 0);
      2:       m_if.m_ready = (beats < 40);
      default: m_if.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: timing bookkeeping, stall stability, and per-beat reference compare.
  always @(negedge CLK) begin : mon
    int rel;
    int k;
    rel = cyc - t0;
    if (acc_clr) begin
      if (clr_cnt == 0) first_clr_rel = rel;
      clr_cnt++;
    end
    if (acc_en) begin
      if (en_cnt == 0) first_en_rel = rel;
      if (!prev_en) en_runs++;
      en_cnt++;
    end
    prev_en = acc_en;
    if (done) done_cnt++;
    if (err) begin
      if (err_cnt == 0) err_rel = rel;
      err_cnt++;
    end
    if (busy) busy_cnt++;
    if (m_if.m_valid) valid_cnt++;
    if (busy && idx_out < cur_first) wrapped = 1'b1;
    if (prev_valid && !prev_ready && !prev_skip) begin
      check_val("hold_valid", m_if.m_valid, 1);
      check_val("hold_data", m_if.m_data, prev_data);
      check_val("hold_idx", m_if.m_idx, prev_idx);
      check_val("hold_last", m_if.m_last, prev_last);
    end
    if (m_if.m_valid && m_if.m_ready) begin
      k = beats % NUM_WORDS;
      check_val("beat_data", m_if.m_data, acc[k]);
      check_val("beat_idx", m_if.m_idx, IDX_W'(cur_first + beats / NUM_WORDS));
      check_val("beat_last", m_if.m_last, (k == NUM_WORDS - 1));
      beats++;
    end
    prev_valid = m_if.m_valid;
    prev_ready = m_if.m_ready;
    prev_data  = m_if.m_data;
    prev_idx   = m_if.m_idx;
    prev_last  = m_if.m_last;
    prev_skip  = abort || !RST_n;
  end

  task automatic do_start(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l);
    @(posedge CLK); #1;
    idx_first = f; idx_last = l; start = 1'b1; t0 = cyc;
    beats = 0; clr_cnt = 0; en_cnt = 0; en_runs = 0; done_cnt = 0; err_cnt = 0;
    busy_cnt = 0; valid_cnt = 0; first_clr_rel = -1; first_en_rel = -1; err_rel = -1;
    cur_first = f; wrapped = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while ((busy || k < 3) && k < budget);
    @(negedge CLK);
    check_val("sweep_end_busy", busy, 0);
  endtask

  task automatic check_sweep(input int nidx);
    check_val("n_beats", beats, NUM_WORDS * nidx);
    check_val("n_acc_clr", clr_cnt, nidx);
    check_val("n_acc_en", en_cnt, SAMPLE * nidx);
    check_val("n_en_runs", en_runs, nidx);
    check_val("n_done", done_cnt, 1);
    check_val("n_err", err_cnt, 0);
    check_val("no_wrap", wrapped, 0);
  endtask

  initial begin
    int f, n, l, k;
    bit reached;
    m_if.m_ready = 1'b1;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_idx_out", idx_out, 0);
    check_val("rst_sel", {sel1, sel2}, 0);
    check_val("rst_m_data", m_if.m_data, 0);
    check_val("rst_m_idx", m_if.m_idx, 0);
    check_val("rst_flags", {acc_clr, acc_en, m_if.m_valid, m_if.m_last, busy, done, err}, 0);
    @(posedge CLK); #1;
    RST_n = 1'b1;

    // Single index with timing of clear and sample window.
    do_start(14'h0005, 14'h0005);
    wait_end(3000);
    check_sweep(1);
    check_val("clr_cycle", first_clr_rel, 3);
    check_val("en_first_cycle", first_en_rel, 4);
    check_val("idx_out_end", idx_out, 14'h0005);

    // Three indices, with a start pulse mid-sweep that must be ignored.
    do_start(14'h0010, 14'h0012);
    repeat (50) @(posedge CLK);
    #1; idx_first = '0; idx_last = '0; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    wait_end(3000);
    check_sweep(3);

    // Back-pressure one cycle in three.
    rdy_mode = 1;
    f = $urandom_range(0, 16000);
    do_start(IDX_W'(f), IDX_W'(f));
    wait_end(3000);
    check_sweep(1);
    rdy_mode = 0;

    // Reversed range.
    do_start(14'h0020, 14'h001F);
    wait_end(50);
    check_val("bad_err_cnt", err_cnt, 1);
    check_val("bad_err_cycle", err_rel, 1);
    check_val("bad_busy", busy_cnt, 0);
    check_val("bad_beats", valid_cnt, 0);

    // Abort while beat 40 is stalled, then a clean restart.
    rdy_mode = 2;
    do_start(14'h0040, 14'h0041);
    reached = 1'b0;
    for (k = 0; k < 2000 && !reached; k++) begin
      @(negedge CLK);
      if (m_if.m_valid && !m_if.m_ready && beats == 40) reached = 1'b1;
    end
    check_val("abort_reach", reached, 1);
    @(posedge CLK); #1; abort = 1'b1;
    @(posedge CLK); #1; abort = 1'b0;
    @(negedge CLK);
    check_val("abort_valid", m_if.m_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_acc_en", acc_en, 0);
    valid_cnt = 0;
    repeat (20) @(negedge CLK);
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_no_beats", valid_cnt, 0);
    rdy_mode = 0;
    do_start(14'h0040, 14'h0040);
    wait_end(3000);
    check_sweep(1);

    // Top of index space.
    do_start(14'h3FFF, 14'h3FFF);
    wait_end(3000);
    check_sweep(1);
    check_val("top_idx_out", idx_out, 14'h3FFF);

    // Reset mid-sweep.
    do_start(14'h0123, 14'h0124);
    reached = 1'b0;
    for (k = 0; k < 2000 && !reached; k++) begin
      @(negedge CLK);
      if (beats >= 10) reached = 1'b1;
    end
    check_val("rst_reach", reached, 1);
    @(posedge CLK); #1; RST_n = 1'b0;
    @(posedge CLK); #1; RST_n = 1'b1;
    @(negedge CLK);
    check_val("midrst_valid", m_if.m_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_m_data", m_if.m_data, 0);
    valid_cnt = 0;
    repeat (30) @(negedge CLK);
    check_val("midrst_no_beats", valid_cnt, 0);

    // Random ranges with random back-pressure.
    for (int i = 0; i < 4; i++) begin
      rdy_mode = 3;
      f = $urandom_range(0, 16383);
      n = $urandom_range(0, 2);
      l = (f + n > 16383) ? 16383 : f + n;
      do_start(IDX_W'(f), IDX_W'(l));
      wait_end(2000 * (l - f + 1));
      check_sweep(l - f + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
